// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, reserve port, read ports and clear control.
// Strobes (clear, wr_en, rsv_en, rd_en) are sampled at the rising edge; there is no ready, busy is the only stall indication.
interface regfile_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     clear;
  logic                     busy;
  logic                     dbg_state;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W/8-1:0]      wr_be;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;

  modport master (
    output clear, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr, rd_en, rd_addr,
    input  busy, dbg_state, rd_data, rd_pend
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_data, wr_be, rsv_en, rsv_addr, rd_en, rd_addr,
    output busy, dbg_state, rd_data, rd_pend
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write, write-to-read bypass,
// per-entry pending scoreboard and a sequential clear sweep (no parallel reset of storage).
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {ST_READY = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              ready, clear_ok, wr_ok, rsv_ok;

  // reset overrides everything, so qualify all READY-side actions with it
  assign ready    = (state_q == ST_READY) && !reset;
  assign clear_ok = ready && bus.clear;
  assign wr_ok    = ready && !bus.clear && bus.wr_en  && (bus.wr_addr  != '0);
  assign rsv_ok   = ready && !bus.clear && bus.rsv_en && (bus.rsv_addr != '0);

  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_READY: begin
        if (bus.clear) begin
          state_d = ST_CLEAR;
          ptr_d   = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset so it can map onto RAM; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  // Reserve is applied after the write-clear so it wins on a same-address collision.
  always_comb begin
    pend_d = pend_q;
    if (clear_ok) begin
      pend_d = '0;
    end else begin
      if (wr_ok)  pend_d[bus.wr_addr]  = 1'b0;
      if (rsv_ok) pend_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word, data_q, data_d;
    logic              pnd_q, pnd_d;

    assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      word = mem[addr];
      if (wr_ok && (bus.wr_addr == addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) word[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
      end
      data_d = data_q;
      pnd_d  = pnd_q;
      if (bus.rd_en[p]) begin
        if ((state_q == ST_CLEAR) || (addr == '0)) begin
          data_d = '0;
          pnd_d  = 1'b0;
        end else if (clear_ok) begin
          // the accepting cycle still sees pre-clear contents, unbypassed
          data_d = mem[addr];
          pnd_d  = pend_q[addr];
        end else begin
          data_d = word;
          pnd_d  = pend_d[addr];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
        pnd_q  <= 1'b0;
      end else begin
        data_q <= data_d;
        pnd_q  <= pnd_d;
      end
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = data_q;
    assign bus.rd_pend[p]                  = pnd_q;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file.
module tb_regfile_mp;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int NB     = DATA_W / 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mem_m [DEPTH];
  logic [DEPTH-1:0]  pend_m;
  int                sweep_left;
  logic [DATA_W-1:0] exp_data [NUM_RD];
  logic              exp_pend [NUM_RD];
  logic              was_en   [NUM_RD];
  logic [DATA_W-1:0] exp_q [$];
  logic              pend_q_exp [$];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] port_data(input int p);
    return bus.rd_data[p*DATA_W +: DATA_W];
  endfunction

  // Apply one clock cycle of the current inputs to the model, then advance the DUT.
  task automatic tick();
    logic              rdy, wv, rv;
    logic [ADDR_W-1:0] a;
    logic [DEPTH-1:0]  new_pend;
    logic [DATA_W-1:0] d;
    logic              pd;
    rdy = (sweep_left == 0);
    if (reset) begin
      sweep_left = DEPTH - 1;
      pend_m     = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        exp_data[p] = '0;
        exp_pend[p] = 1'b0;
        was_en[p]   = 1'b0;
      end
    end else begin
      wv = rdy && !bus.clear && bus.wr_en  && (bus.wr_addr  != 0);
      rv = rdy && !bus.clear && bus.rsv_en && (bus.rsv_addr != 0);
      new_pend = pend_m;
      if (wv) new_pend[bus.wr_addr]  = 1'b0;
      if (rv) new_pend[bus.rsv_addr] = 1'b1;
      for (int p = 0; p < NUM_RD; p++) begin
        was_en[p] = bus.rd_en[p];
        if (bus.rd_en[p]) begin
          a = bus.rd_addr[p*ADDR_W +: ADDR_W];
          if (!rdy || a == 0) begin
            d  = '0;
            pd = 1'b0;
          end else if (bus.clear) begin
            d  = mem_m[a];
            pd = pend_m[a];
          end else begin
            d  = (wv && bus.wr_addr == a) ? merge(mem_m[a], bus.wr_data, bus.wr_be) : mem_m[a];
            pd = new_pend[a];
          end
          exp_data[p] = d;
          exp_pend[p] = pd;
          exp_q.push_back(d);
          pend_q_exp.push_back(pd);
        end
      end
      if (!rdy) begin
        sweep_left--;
      end else if (bus.clear) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        pend_m     = '0;
        sweep_left = DEPTH - 1;
      end else begin
        if (wv) mem_m[bus.wr_addr] = merge(mem_m[bus.wr_addr], bus.wr_data, bus.wr_be);
        pend_m = new_pend;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.clear    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
    bus.rd_en[p]                    = 1'b1;
    bus.rd_addr[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [NB-1:0] be);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cnt;
    idle();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_busy: got %b want 1", bus.busy);
    end
    checks++;
    if (bus.rd_data !== '0) begin
      errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data);
    end
    checks++;
    if (bus.rd_pend !== '0) begin
      errors++; $display("FAIL reset_rd_pend: got %b want 0", bus.rd_pend);
    end
    reset = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
      checks++;
      if (bus.busy !== (sweep_left != 0)) begin
        errors++; $display("FAIL sweep_busy: cycle %0d got %b want %b", cnt, bus.busy, sweep_left != 0);
      end
    end while (bus.busy && cnt < 200);
    checks++;
    if (cnt != DEPTH - 1) begin
      errors++; $display("FAIL reset_sweep_len: got %0d want %0d", cnt, DEPTH - 1);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, ADDR_W'(a));
      set_rd(1, ADDR_W'(DEPTH - 1 - a));
      tick();
      checks++;
      if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
        errors++; $display("FAIL post_reset_read: addr %0d got %h/%b want 0/0", a, bus.rd_data, bus.rd_pend);
      end
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    set_wr(5, 16'hBEEF, 2'b11);
    set_rd(0, 5);
    tick();
    checks++;
    if (port_data(0) !== 16'hBEEF || port_data(0) !== exp_data[0]) begin
      errors++; $display("FAIL bypass_full: got %h want BEEF", port_data(0));
    end
    set_wr(5, 16'h1234, 2'b01);
    tick();
    checks++;
    if (port_data(0) !== 16'hBE34) begin
      errors++; $display("FAIL bypass_partial: got %h want BE34", port_data(0));
    end
    idle();
    set_rd(1, 5);
    tick();
    checks++;
    if (port_data(1) !== 16'hBE34 || bus.rd_pend[1] !== 1'b0) begin
      errors++; $display("FAIL written_visible: got %h/%b want BE34/0", port_data(1), bus.rd_pend[1]);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(0, 16'hFFFF, 2'b11);
    bus.rsv_en = 1'b1; bus.rsv_addr = 0;
    set_rd(0, 0);
    set_rd(1, 0);
    tick();
    checks++;
    if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
      errors++; $display("FAIL zero_reg_same: got %h/%b want 0/0", bus.rd_data, bus.rd_pend);
    end
    idle();
    set_rd(0, 0);
    set_rd(1, 0);
    tick();
    checks++;
    if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
      errors++; $display("FAIL zero_reg_after: got %h/%b want 0/0", bus.rd_data, bus.rd_pend);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 7;
    tick();
    idle();
    set_rd(0, 7);
    tick();
    checks++;
    if (bus.rd_pend[0] !== 1'b1) begin
      errors++; $display("FAIL reserve_pend: got %b want 1", bus.rd_pend[0]);
    end
    set_wr(7, 16'h5A5A, 2'b11);
    tick();
    checks++;
    if (bus.rd_pend[0] !== 1'b0 || port_data(0) !== 16'h5A5A) begin
      errors++; $display("FAIL write_clears_pend: got %h/%b want 5A5A/0", port_data(0), bus.rd_pend[0]);
    end
    set_wr(7, 16'h0F0F, 2'b11);
    bus.rsv_en = 1'b1; bus.rsv_addr = 7;
    set_rd(1, 7);
    tick();
    checks++;
    if (bus.rd_pend !== 2'b11 || port_data(1) !== 16'h0F0F) begin
      errors++; $display("FAIL reserve_wins: got %h/%b want 0F0F/11", port_data(1), bus.rd_pend);
    end
    idle();
    set_rd(0, 7);
    tick();
    checks++;
    if (bus.rd_pend[0] !== 1'b1 || port_data(0) !== 16'h0F0F) begin
      errors++; $display("FAIL reserve_wins_after: got %h/%b want 0F0F/1", port_data(0), bus.rd_pend[0]);
    end
    idle();
  endtask

  task automatic test_multiport_hold();
    idle();
    set_wr(2, 16'h2222, 2'b11);
    tick();
    set_wr(9, 16'h9999, 2'b11);
    tick();
    idle();
    set_rd(0, 2);
    set_rd(1, 9);
    tick();
    checks++;
    if (port_data(0) !== 16'h2222 || port_data(1) !== 16'h9999) begin
      errors++; $display("FAIL multiport: got %h %h want 2222 9999", port_data(0), port_data(1));
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = NUM_RD*ADDR_W'($urandom);
      set_wr(2, DATA_W'($urandom), 2'b11);
      bus.rsv_en = 1'b1; bus.rsv_addr = 9;
      tick();
      checks++;
      if (port_data(0) !== 16'h2222 || port_data(1) !== 16'h9999 || bus.rd_pend !== 2'b00) begin
        errors++; $display("FAIL hold: cycle %0d got %h %h %b want 2222 9999 00", i, port_data(0), port_data(1), bus.rd_pend);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    int cnt;
    idle();
    for (int i = 1; i < DEPTH; i++) begin
      set_wr(ADDR_W'(i), DATA_W'(i), 2'b11);
      tick();
    end
    set_wr(3, 16'hAAAA, 2'b11);
    bus.clear = 1'b1;
    set_rd(0, 3);
    set_rd(1, 4);
    tick();
    checks++;
    if (port_data(0) !== 16'h0003 || port_data(1) !== 16'h0004 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL clear_accept: got %h %h busy %b want 0003 0004 busy 1", port_data(0), port_data(1), bus.busy);
    end
    idle();
    cnt = 0;
    do begin
      set_wr(ADDR_W'($urandom_range(1, DEPTH - 1)), DATA_W'($urandom), 2'b11);
      bus.clear = 1'(cnt == 5);
      set_rd(0, ADDR_W'($urandom_range(1, DEPTH - 1)));
      set_rd(1, ADDR_W'($urandom_range(1, DEPTH - 1)));
      tick();
      cnt++;
      checks++;
      if (bus.rd_data !== '0 || bus.rd_pend !== '0 || bus.dbg_state !== (sweep_left != 0)) begin
        errors++; $display("FAIL read_in_clear: cycle %0d got %h/%b want 0/0", cnt, bus.rd_data, bus.rd_pend);
      end
    end while (bus.busy && cnt < 200);
    checks++;
    if (cnt != DEPTH - 1) begin
      errors++; $display("FAIL clear_sweep_len: got %0d want %0d", cnt, DEPTH - 1);
    end
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, ADDR_W'(a));
      set_rd(1, ADDR_W'(a));
      tick();
      checks++;
      if (bus.rd_data !== '0 || bus.rd_pend !== '0) begin
        errors++; $display("FAIL post_clear_read: addr %0d got %h/%b want 0/0", a, bus.rd_data, bus.rd_pend);
      end
    end
    idle();
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    idle();
    bus.clear = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL midsweep_reset_busy: got %b want 1", bus.busy);
    end
    reset = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.busy && cnt < 200);
    checks++;
    if (cnt != DEPTH - 1) begin
      errors++; $display("FAIL midsweep_len: got %0d want %0d", cnt, DEPTH - 1);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic              pd;
    idle();
    exp_q.delete();
    pend_q_exp.delete();
    for (int i = 0; i < 600; i++) begin
      bus.clear    = 1'($urandom_range(0, 199) == 0);
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
      bus.wr_data  = DATA_W'($urandom);
      bus.wr_be    = NB'($urandom);
      bus.rsv_en   = 1'($urandom_range(0, 2) == 0);
      bus.rsv_addr = ADDR_W'($urandom_range(0, 7));
      bus.rd_en    = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++)
        bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
      tick();
      checks++;
      if (bus.busy !== (sweep_left != 0)) begin
        errors++; $display("FAIL rand_busy: iter %0d got %b want %b", i, bus.busy, sweep_left != 0);
      end
      for (int p = 0; p < NUM_RD; p++) begin
        if (was_en[p] && exp_q.size() > 0) begin
          d  = exp_q.pop_front();
          pd = pend_q_exp.pop_front();
          checks++;
          if (port_data(p) !== d || bus.rd_pend[p] !== pd) begin
            errors++; $display("FAIL rand_read: iter %0d port %0d got %h/%b want %h/%b", i, p, port_data(p), bus.rd_pend[p], d, pd);
          end
        end
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    sweep_left = DEPTH - 1;
    pend_m     = '0;
    reset      = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_multiport_hold();
    test_clear();
    test_reset_midsweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
